dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single-port, synchronous-read data memory between two requesters: the core load/store path and a debug/program-loader port.
- Sits between the core's memory interface and the data memory.
- Arbitrates one access per cycle and routes 1-cycle-latency read data back to the owner.
- Stalls the core while it is denied, and bounds debug starvation with a wait counter.

Parameters:
- ADDR_W, 10: word-address width driven to memory (memory depth 2^ADDR_W words).
- DATA_W, 32: data width.
- STARVE_LIMIT, 4: consecutive denied debug cycles before debug is forced to win; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  synchronous reset, active-high. Asserted = 1, despite the name.
- core_req  in  1  core access request; held until granted.
- core_we  in  1  1 = store, 0 = load.
- core_addr  in  32  byte address.
- core_wdata  in  DATA_W  store data.
- core_gnt  out  1  core access issued this cycle.
- core_stall  out  1  core_req & ~core_gnt.
- core_rvalid  out  1  core load data valid.
- core_rdata  out  DATA_W  core load data.
- dbg_req, dbg_we, dbg_addr(32), dbg_wdata(DATA_W)  in  debug request; same rules as the core request.
- dbg_gnt, dbg_rvalid, dbg_rdata(DATA_W)  out  debug grant and read response.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  word address = granted addr[ADDR_W+1:2].
- mem_wdata  out  DATA_W  granted write data.
- mem_rdata  in  DATA_W  read data, valid the cycle after mem_en & ~mem_we.

Behaviour:
- Grants are combinational from the requests and registered state. At most one of core_gnt/dbg_gnt is high per cycle.
- When granted, the mem_* outputs carry that requester's fields in the same cycle. mem_en = core_gnt | dbg_gnt.
- Idle cycle: mem_en = mem_we = 0, and mem_addr/mem_wdata are driven 0.
- Priority: core wins on contention, unless starve_cnt == STARVE_LIMIT, in which case debug wins.
- starve_cnt (4 bits):
  - +1 on each cycle with dbg_req & ~dbg_gnt, saturating at STARVE_LIMIT.
  - Cleared on dbg_gnt.
  - Holds when dbg_req = 0.
- Read tracking: registered rd_owner in {NONE, CORE, DBG}, set on the grant cycle of a load, else NONE.
- In the next cycle:
  - The owner's rvalid = 1 and its rdata = mem_rdata.
  - The other requester's rdata is 0.
- Fully pipelined: back-to-back grants are allowed, and a new grant may coincide with the previous load's rvalid.
- Stores produce no rvalid.
- Address bits [1:0] and those above ADDR_W+1 are ignored; misaligned and out-of-range accesses alias silently.
- Reset (reset_n = 1 at an edge):
  - starve_cnt = 0, rd_owner = NONE, last_gnt = CORE.
  - While reset_n is high, all grants, rvalids and mem_en are forced to 0, and core_stall = 0.
  - An in-flight load is dropped: no rvalid in the cycle after reset.
- Requests asserted during reset are serviced in the first cycle after reset_n deasserts.

Optional Feature:
- Macro DMEM_ARB_RR_EN.
- Defined:
  - Round-robin arbitration. On contention, the requester opposite last_gnt wins; last_gnt updates on every grant.
  - starve_cnt is not implemented and STARVE_LIMIT is ignored.
- Undefined: fixed core priority with the starvation override described above. last_gnt is not implemented.

Decomposition:
- Shared package dmem_arb_pkg holds:
  - the owner_e enum {OWN_NONE, OWN_CORE, OWN_DBG};
  - the word-address offset constant (2).
- One natural sub-module, dmem_arb_select: the combinational grant decision, taking both requests, starve_cnt/last_gnt and the limit, and returning a one-hot grant.
- Counter, owner register and muxes stay in dmem_arbiter.

Test Plan:
- Core load only:
  - Stimulus: core_req = 1, we = 0, addr = 0x10, memory word 4 = 0xDEADBEEF.
  - Response: core_gnt = 1 and mem_addr = 4 in cycle 0; core_rvalid = 1 and core_rdata = 0xDEADBEEF in cycle 1; dbg_rvalid = 0.
- Contention with STARVE_LIMIT = 4:
  - Stimulus: core_req and dbg_req held high.
  - Response: core granted cycles 0-3; dbg granted cycle 4 with core_stall = 1; core granted again cycle 5; starve_cnt reads 0 after cycle 4.
- Back-to-back loads:
  - Stimulus: core load addr 0x0 in cycle 0, then dbg load addr 0x4 in cycle 1.
  - Response: core_rvalid in cycle 1, dbg_rvalid in cycle 2, each with its own word; no cross-routing.
- Store then load:
  - Stimulus: dbg stores 0x12345678 at addr 0x8, then the core loads addr 0x8.
  - Response: core_rdata = 0x12345678; no rvalid for the store.
- Reset mid-load:
  - Stimulus: core load granted in cycle 0, reset_n = 1 in cycle 1.
  - Response: core_rvalid = 0 in cycles 1-2; mem_en = 0 during reset; starve_cnt = 0 afterwards.
- With DMEM_ARB_RR_EN:
  - Stimulus: both requesters held high for 6 cycles.
  - Response: grants alternate dbg, core, dbg, core, dbg, core (last_gnt = CORE after reset).

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Optional round-robin build: define DMEM_ARB_RR_EN.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CORE,
    OWN_DBG
  } owner_e;

  localparam int WORD_OFS = 2;
  localparam int GNT_CORE = 0;
  localparam int GNT_DBG  = 1;

endpackage

// File: rtl/dmem_arb_if.sv
// Requester, response and memory-side signals of the arbiter.
// slave = arbiter side, master = requesters plus memory.
interface dmem_arb_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);

  logic              core_req;
  logic              core_we;
  logic [31:0]       core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_gnt;
  logic              core_stall;
  logic              core_rvalid;
  logic [DATA_W-1:0] core_rdata;

  logic              dbg_req;
  logic              dbg_we;
  logic [31:0]       dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_gnt, core_stall, core_rvalid, core_rdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_gnt, core_stall, core_rvalid, core_rdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_arb_select.sv
// Combinational grant decision; returns a one-hot {dbg, core} grant.
// DMEM_ARB_RR_EN selects round-robin instead of core-priority.
module dmem_arb_select
  import dmem_arb_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic       i_core_req,
  input  logic       i_dbg_req,
  input  logic [3:0] i_starve_cnt,
  input  logic       i_last_dbg,
  output logic [1:0] o_gnt
);

  logic w_dbg_wins;
  logic w_unused;

`ifdef DMEM_ARB_RR_EN
  assign w_dbg_wins = ~i_last_dbg;
  assign w_unused   = ^i_starve_cnt;
`else
  assign w_dbg_wins = (i_starve_cnt == 4'(LIMIT));
  assign w_unused   = i_last_dbg;
`endif

  always_comb begin
    o_gnt           = '0;
    o_gnt[GNT_CORE] = i_core_req & ~(i_dbg_req & w_dbg_wins);
    o_gnt[GNT_DBG]  = i_dbg_req & ~(i_core_req & ~w_dbg_wins);
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a 1-cycle sync-read data memory between core and debug ports.
// Define DMEM_ARB_RR_EN for round-robin instead of starvation-bounded priority.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic   clk,
  input  logic   reset_n,
  dmem_arb_if.slave bus
);

  logic [1:0] w_gnt;
  logic       w_core_gnt;
  logic       w_dbg_gnt;
  logic [3:0] w_starve_cnt;
  logic       w_last_dbg;
  logic       w_core_rv;
  logic       w_dbg_rv;
  logic       w_unused;
  owner_e     r_rd_owner;

  // reset_n is active-high: no grants while it is asserted
  dmem_arb_select #(
    .LIMIT(STARVE_LIMIT)
  ) u_sel (
    .i_core_req  (bus.core_req & ~reset_n),
    .i_dbg_req   (bus.dbg_req & ~reset_n),
    .i_starve_cnt(w_starve_cnt),
    .i_last_dbg  (w_last_dbg),
    .o_gnt       (w_gnt)
  );

  assign w_core_gnt = w_gnt[GNT_CORE];
  assign w_dbg_gnt  = w_gnt[GNT_DBG];

  assign bus.core_gnt   = w_core_gnt;
  assign bus.dbg_gnt    = w_dbg_gnt;
  assign bus.core_stall = bus.core_req & ~reset_n & ~w_core_gnt;
  assign bus.mem_en     = w_core_gnt | w_dbg_gnt;

  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    unique case (1'b1)
      w_core_gnt: begin
        bus.mem_we    = bus.core_we;
        bus.mem_addr  = bus.core_addr[ADDR_W+WORD_OFS-1:WORD_OFS];
        bus.mem_wdata = bus.core_wdata;
      end
      w_dbg_gnt: begin
        bus.mem_we    = bus.dbg_we;
        bus.mem_addr  = bus.dbg_addr[ADDR_W+WORD_OFS-1:WORD_OFS];
        bus.mem_wdata = bus.dbg_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_n)
      r_rd_owner <= OWN_NONE;
    else if (w_core_gnt & ~bus.core_we)
      r_rd_owner <= OWN_CORE;
    else if (w_dbg_gnt & ~bus.dbg_we)
      r_rd_owner <= OWN_DBG;
    else
      r_rd_owner <= OWN_NONE;
  end

  assign w_core_rv = ~reset_n & (r_rd_owner == OWN_CORE);
  assign w_dbg_rv  = ~reset_n & (r_rd_owner == OWN_DBG);

  assign bus.core_rvalid = w_core_rv;
  assign bus.dbg_rvalid  = w_dbg_rv;
  assign bus.core_rdata  = w_core_rv ? bus.mem_rdata : '0;
  assign bus.dbg_rdata   = w_dbg_rv ? bus.mem_rdata : '0;

`ifdef DMEM_ARB_RR_EN
  logic r_last_dbg;

  always_ff @(posedge clk) begin
    if (reset_n)
      r_last_dbg <= 1'b0;
    else if (w_core_gnt)
      r_last_dbg <= 1'b0;
    else if (w_dbg_gnt)
      r_last_dbg <= 1'b1;
  end

  assign w_last_dbg   = r_last_dbg;
  assign w_starve_cnt = 4'd0;
`else
  logic [3:0] r_starve_cnt;

  always_ff @(posedge clk) begin
    if (reset_n)
      r_starve_cnt <= 4'd0;
    else if (w_dbg_gnt)
      r_starve_cnt <= 4'd0;
    else if (bus.dbg_req && r_starve_cnt != 4'(STARVE_LIMIT))
      r_starve_cnt <= r_starve_cnt + 4'd1;
  end

  assign w_last_dbg   = 1'b0;
  assign w_starve_cnt = r_starve_cnt;
`endif

  // address bits outside the word index alias silently
  assign w_unused = ^{bus.core_addr[31:ADDR_W+WORD_OFS],
                      bus.core_addr[WORD_OFS-1:0],
                      bus.dbg_addr[31:ADDR_W+WORD_OFS],
                      bus.dbg_addr[WORD_OFS-1:0]};

endmodule
